maxpool_stream_1d: RTL and testbench

Streaming 1-D max-pooling stage placed directly downstream of a conv layer (e.g. `layer2_5_3_8_1`). It consumes the layer's post-ReLU signed output vector over a valid/ready handshake and reduces each group of POOL consecutive samples to their signed maximum. It emits the pooled vector on a second valid/ready handshake, with an end-of-frame marker. Frames are LENX samples long; a trailing partial group at the end of a frame is pooled on its own.

---
 rtl/maxpool_stream_1d.sv | 118 +++++++++++
 tb/tb_maxpool_stream_1d.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_1d.sv
// rtl/maxpool_stream_1d.sv - streaming 1-D signed max-pooling stage
//
// Reduces each group of POOL consecutive signed samples to its maximum.
// Frames are LENX samples long; a trailing partial group is pooled on its own,
// so a frame yields ceil(LENX/POOL) results.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high
//   s_data_in_x   in   WIDTH signed input sample
//   s_valid_x     in   input sample valid
//   s_ready_x     out  block can accept a sample
//   m_data_out_y  out  WIDTH signed pooled result
//   m_valid_y     out  result valid
//   m_ready_y     in   downstream accepts result
//   m_last_y      out  final pooled result of a frame
module maxpool_stream_1d #(
  parameter int WIDTH = 8,
  parameter int LENX  = 3,
  parameter int POOL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             m_last_y
);

  localparam int CNT_W = (LENX > 1) ? $clog2(LENX) : 1;
  localparam int GRP_W = (POOL > 1) ? $clog2(POOL) : 1;

  logic [GRP_W-1:0]        grp_cnt_q, grp_cnt_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic signed [WIDTH-1:0] cur_max_q, cur_max_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] cand;
  logic                    in_fire;
  logic                    out_fire;
  logic                    frame_end;
  logic                    grp_end;

  // Input only stalls while a result is held unaccepted; mid-group samples
  // stall too, which keeps the datapath a single register deep.
  assign s_ready_x    = !(valid_q && !m_ready_y);
  assign m_data_out_y = data_q;
  assign m_valid_y    = valid_q;
  assign m_last_y     = last_q;

  assign sample    = s_data_in_x;
  assign in_fire   = s_valid_x && s_ready_x;
  assign out_fire  = valid_q && m_ready_y;
  assign frame_end = (in_cnt_q == CNT_W'(LENX - 1));
  assign grp_end   = (grp_cnt_q == GRP_W'(POOL - 1)) || frame_end;

  // Ties keep cur_max, which carries the same value as the sample.
  always_comb begin
    cand = sample;
    if (grp_cnt_q != '0) begin
      cand = (sample > cur_max_q) ? sample : cur_max_q;
    end
  end

  always_comb begin
    grp_cnt_d = grp_cnt_q;
    in_cnt_d  = in_cnt_q;
    cur_max_d = cur_max_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;

    if (out_fire) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (in_fire) begin
      if (grp_end) begin
        // A closing group overrides the clear above, so a result accepted
        // in this cycle is replaced without a bubble.
        data_d    = cand;
        valid_d   = 1'b1;
        last_d    = frame_end;
        grp_cnt_d = '0;
      end else begin
        cur_max_d = cand;
        grp_cnt_d = grp_cnt_q + GRP_W'(1);
      end
      in_cnt_d = frame_end ? '0 : in_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_cnt_q <= '0;
      in_cnt_q  <= '0;
      cur_max_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      grp_cnt_q <= grp_cnt_d;
      in_cnt_q  <= in_cnt_d;
      cur_max_q <= cur_max_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_maxpool_stream_1d.sv
// tb/tb_maxpool_stream_1d.sv - directed bench for maxpool_stream_1d
module tb_maxpool_stream_1d;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // a: LENX=3 POOL=2, b: LENX=3 POOL=1, c: LENX=5 POOL=2
  logic [7:0] a_din, b_din, c_din;
  logic       a_sv, b_sv, c_sv;
  logic       a_sr, b_sr, c_sr;
  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_mv, b_mv, c_mv;
  logic       a_mr, b_mr, c_mr;
  logic       a_ml, b_ml, c_ml;

  maxpool_stream_1d #(.WIDTH(8), .LENX(3), .POOL(2)) u_a (
    .clk(clk), .reset(reset),
    .s_data_in_x(a_din), .s_valid_x(a_sv), .s_ready_x(a_sr),
    .m_data_out_y(a_dout), .m_valid_y(a_mv), .m_ready_y(a_mr), .m_last_y(a_ml)
  );

  maxpool_stream_1d #(.WIDTH(8), .LENX(3), .POOL(1)) u_b (
    .clk(clk), .reset(reset),
    .s_data_in_x(b_din), .s_valid_x(b_sv), .s_ready_x(b_sr),
    .m_data_out_y(b_dout), .m_valid_y(b_mv), .m_ready_y(b_mr), .m_last_y(b_ml)
  );

  maxpool_stream_1d #(.WIDTH(8), .LENX(5), .POOL(2)) u_c (
    .clk(clk), .reset(reset),
    .s_data_in_x(c_din), .s_valid_x(c_sv), .s_ready_x(c_sr),
    .m_data_out_y(c_dout), .m_valid_y(c_mv), .m_ready_y(c_mr), .m_last_y(c_ml)
  );

  // Drive instance a on the falling edge, return 1 time unit after the
  // following rising edge so registered outputs can be sampled.
  task automatic drive_a(input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    a_sv = v;
    a_din = d;
    a_mr = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_sv = 0; a_din = 0; a_mr = 0;
    b_sv = 0; b_din = 0; b_mr = 0;
    c_sv = 0; c_din = 0; c_mr = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_mv, a_ml, a_dout} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", {a_mv, a_ml, a_dout}, 10'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_sr, b_sr, c_sr} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 111", {a_sr, b_sr, c_sr});
    end
  endtask

  task automatic test_basic;
    logic [7:0] din [3];
    logic [9:0] exp [3];
    din = '{8'd5, 8'hFD, 8'd7};
    exp = '{10'b0, {2'b10, 8'd5}, {2'b11, 8'd7}};
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, din[i], 1'b1);
      n_checks++;
      if (exp[i][9] ? ({a_mv, a_ml, a_dout} !== exp[i]) : (a_mv !== 1'b0)) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %b want %b", i, {a_mv, a_ml, a_dout}, exp[i]);
      end
    end
    drive_a(1'b0, 8'd0, 1'b1);
    n_checks++;
    if (a_mv !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got valid %b want 0", a_mv);
    end
  endtask

  task automatic test_signed;
    logic [7:0] din [6];
    logic [9:0] exp [6];
    din = '{8'hF8, 8'hFE, 8'h80, 8'h7F, 8'h80, 8'h00};
    exp = '{10'b0, {2'b10, 8'hFE}, {2'b11, 8'h80}, 10'b0, {2'b10, 8'h7F}, {2'b11, 8'h00}};
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, din[i], 1'b1);
      n_checks++;
      if (exp[i][9] ? ({a_mv, a_ml, a_dout} !== exp[i]) : (a_mv !== 1'b0)) begin
        n_fail++;
        $display("FAIL signed[%0d]: got %b want %b", i, {a_mv, a_ml, a_dout}, exp[i]);
      end
    end
    drive_a(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_backpressure;
    drive_a(1'b1, 8'd5, 1'b1);
    drive_a(1'b1, 8'hFD, 1'b0);
    n_checks++;
    if ({a_mv, a_ml, a_dout} !== {2'b10, 8'd5}) begin
      n_fail++;
      $display("FAIL bp_hold0: got %b want %b", {a_mv, a_ml, a_dout}, {2'b10, 8'd5});
    end
    @(negedge clk);
    a_sv = 1'b1; a_din = 8'd7; a_mr = 1'b0;
    #1;
    n_checks++;
    if (a_sr !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_low: got %b want 0", a_sr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_mv, a_ml, a_dout} !== {2'b10, 8'd5}) begin
      n_fail++;
      $display("FAIL bp_hold1: got %b want %b", {a_mv, a_ml, a_dout}, {2'b10, 8'd5});
    end
    @(negedge clk);
    a_mr = 1'b1;
    #1;
    n_checks++;
    if (a_sr !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_high: got %b want 1", a_sr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_mv, a_ml, a_dout} !== {2'b11, 8'd7}) begin
      n_fail++;
      $display("FAIL bp_follow: got %b want %b", {a_mv, a_ml, a_dout}, {2'b11, 8'd7});
    end
    drive_a(1'b0, 8'd0, 1'b1);
    n_checks++;
    if (a_mv !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: got valid %b want 0", a_mv);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp [6];
    exp = '{10'b0, {2'b10, 8'd2}, {2'b11, 8'd3}, 10'b0, {2'b10, 8'd5}, {2'b11, 8'd6}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_sv = 1'b1; a_din = 8'(i + 1); a_mr = 1'b1;
      #1;
      n_checks++;
      if (a_sr !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_sr);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (exp[i][9] ? ({a_mv, a_ml, a_dout} !== exp[i]) : (a_mv !== 1'b0)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %b want %b", i, {a_mv, a_ml, a_dout}, exp[i]);
      end
    end
    drive_a(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] din [3];
    logic [9:0] exp [3];
    din = '{8'd1, 8'd4, 8'd2};
    exp = '{10'b0, {2'b10, 8'd4}, {2'b11, 8'd2}};
    drive_a(1'b1, 8'd9, 1'b1);
    @(negedge clk);
    reset = 1'b1; a_sv = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_mv, a_ml, a_dout, a_sr} !== {10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_state: got %b want %b", {a_mv, a_ml, a_dout, a_sr}, {10'd0, 1'b1});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, din[i], 1'b1);
      n_checks++;
      if (exp[i][9] ? ({a_mv, a_ml, a_dout} !== exp[i]) : (a_mv !== 1'b0)) begin
        n_fail++;
        $display("FAIL midreset[%0d]: got %b want %b", i, {a_mv, a_ml, a_dout}, exp[i]);
      end
    end
    drive_a(1'b0, 8'd0, 1'b1);
  endtask

  // POOL=1: identity, last on every third sample; stalls on both sides.
  task automatic test_sweep_pool1;
    logic [7:0] din [6];
    logic [8:0] exp [6];
    int si = 0;
    int ri = 0;
    din = '{8'd3, 8'hFF, 8'hF9, 8'd100, 8'h80, 8'h00};
    exp = '{{1'b0, 8'd3}, {1'b0, 8'hFF}, {1'b1, 8'hF9}, {1'b0, 8'd100}, {1'b0, 8'h80}, {1'b1, 8'h00}};
    for (int cyc = 0; cyc < 200 && ri < 6; cyc++) begin
      @(negedge clk);
      b_sv = (si < 6) && (((cyc * 7 + 3) % 5) != 0);
      b_din = (si < 6) ? din[si] : 8'd0;
      b_mr = ((cyc * 3) % 4) != 1;
      #1;
      if (b_sv && b_sr) si++;
      if (b_mv && b_mr) begin
        n_checks++;
        if ({b_ml, b_dout} !== exp[ri]) begin
          n_fail++;
          $display("FAIL pool1[%0d]: got %b want %b", ri, {b_ml, b_dout}, exp[ri]);
        end
        ri++;
      end
    end
    @(negedge clk);
    b_sv = 1'b0; b_mr = 1'b0;
    n_checks++;
    if (ri != 6) begin
      n_fail++;
      $display("FAIL pool1_timeout: got %0d results want 6", ri);
    end
  endtask

  // LENX=5 POOL=2: three results per frame, last group is one sample.
  task automatic test_sweep_len5;
    logic [7:0] din [10];
    logic [8:0] exp [6];
    int si = 0;
    int ri = 0;
    din = '{8'd1, 8'hFB, 8'd9, 8'd9, 8'hFD, 8'h9C, 8'hA6, 8'd4, 8'h7F, 8'h80};
    exp = '{{1'b0, 8'd1}, {1'b0, 8'd9}, {1'b1, 8'hFD}, {1'b0, 8'hA6}, {1'b0, 8'h7F}, {1'b1, 8'h80}};
    for (int cyc = 0; cyc < 300 && ri < 6; cyc++) begin
      @(negedge clk);
      c_sv = (si < 10) && (((cyc * 7 + 3) % 5) != 0);
      c_din = (si < 10) ? din[si] : 8'd0;
      c_mr = ((cyc * 3) % 4) != 1;
      #1;
      if (c_sv && c_sr) si++;
      if (c_mv && c_mr) begin
        n_checks++;
        if ({c_ml, c_dout} !== exp[ri]) begin
          n_fail++;
          $display("FAIL len5[%0d]: got %b want %b", ri, {c_ml, c_dout}, exp[ri]);
        end
        ri++;
      end
    end
    @(negedge clk);
    c_sv = 1'b0; c_mr = 1'b0;
    n_checks++;
    if (ri != 6) begin
      n_fail++;
      $display("FAIL len5_timeout: got %0d results want 6", ri);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_frame;
    test_sweep_pool1;
    test_sweep_len5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
